// File: rtl/wb_bram_pkg.sv
// Shared types and helpers for the Wishbone-to-BRAM port controller and
// other byte-lane adapters.
package wb_bram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  function automatic int sel_width(int data_width);
    return data_width / 8;
  endfunction

  // One lane of a byte-enable merge: take the new byte where selected.
  function automatic logic [7:0] merge_byte(logic [7:0] old_b, logic [7:0] new_b, logic sel);
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_bram_port_ctrl_merge.sv
// Combinational byte-lane merge: lane i takes i_new when i_sel[i], else i_old.
module wb_byte_merge
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = sel_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_new,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic [DATA_WIDTH-1:0] o_merged
);

  for (genvar g = 0; g < SEL_WIDTH; g++) begin : g_lane
    assign o_merged[g*8 +: 8] = merge_byte(i_old[g*8 +: 8], i_new[g*8 +: 8], i_sel[g]);
  end

endmodule

// File: rtl/wb_bram_port_ctrl.sv
// Wishbone B4 pipelined slave driving one BRAM port; partial-select writes
// become a read followed by a merged write (one stall cycle).
module wb_bram_port_ctrl
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int SEL_WIDTH = sel_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [SEL_WIDTH-1:0]  i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_din,
  input  logic [DATA_WIDTH-1:0] i_bram_dout
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  ack_q, ack_d;
  logic                  rd_q, rd_d;
  logic                  accept, sel_full, sel_none, partial;
  logic [DATA_WIDTH-1:0] merged;

  // Reset gates the combinational RAM drive so an in-flight merge is dropped.
  assign accept   = i_wb_cyc & i_wb_stb & (state_q == ST_IDLE) & ~i_reset;
  assign sel_full = &i_wb_sel;
  assign sel_none = ~|i_wb_sel;
  assign partial  = i_wb_we & ~sel_full & ~sel_none;

  wb_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .i_old    (i_bram_dout),
    .i_new    (data_q),
    .i_sel    (sel_q),
    .o_merged (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    ack_d       = 1'b0;
    rd_d        = 1'b0;
    o_bram_en   = 1'b0;
    o_bram_we   = 1'b0;
    o_bram_addr = '0;
    o_bram_din  = '0;
    if (!i_reset) begin
      case (state_q)
        ST_IDLE: if (accept) begin
          ack_d       = ~partial;
          rd_d        = ~i_wb_we;
          o_bram_en   = ~(i_wb_we & sel_none);
          o_bram_we   = i_wb_we & sel_full;
          o_bram_addr = i_wb_addr;
          if (i_wb_we & sel_full) o_bram_din = i_wb_data;
          if (partial) begin
            state_d = ST_MERGE;
            addr_d  = i_wb_addr;
            data_d  = i_wb_data;
            sel_d   = i_wb_sel;
          end
        end
        ST_MERGE: begin
          // Write completes even if the master abandoned the cycle.
          o_bram_en   = 1'b1;
          o_bram_we   = 1'b1;
          o_bram_addr = addr_q;
          o_bram_din  = merged;
          ack_d       = i_wb_cyc;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  assign o_wb_stall = (state_q == ST_MERGE);
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = (ack_q & rd_q) ? i_bram_dout : '0;

endmodule

// File: tb/tb_wb_bram_port_ctrl.sv
// Directed bench: controller on port A of a behavioural true-dual-port RAM,
// port B driven by the bench for preload and collision stimulus.
module tb_wb_bram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [9:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_sel;
  logic        stall, ack;
  logic [31:0] rdata;
  logic        en, bwe;
  logic [9:0]  baddr;
  logic [31:0] bdin, bdout;
  logic        pb_we;
  logic [9:0]  pb_addr;
  logic [31:0] pb_din;
  logic [31:0] mem [0:1023];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  wb_bram_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_wb_sel(wb_sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata),
    .o_bram_en(en), .o_bram_we(bwe), .o_bram_addr(baddr), .o_bram_din(bdin),
    .i_bram_dout(bdout)
  );

  // Read-first RAM; port A write is applied last so it wins a collision.
  always @(posedge clk) begin
    if (pb_we) mem[pb_addr] <= pb_din;
    if (en) begin
      if (bwe) mem[baddr] <= bdin;
      bdout <= mem[baddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic c, input logic s, input logic w, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] sl);
    cyc = c; stb = s; we = w; wb_addr = a; wb_data = d; wb_sel = sl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bwr(input logic [9:0] a, input logic [31:0] d);
    pb_we = 1'b1; pb_addr = a; pb_din = d;
    tick();
    pb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pb_we = 1'b0; pb_addr = '0; pb_din = '0; bdout = '0;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_we", 32'(bwe), 0);
    chk("rst_addr", 32'(baddr), 0);
    chk("rst_din", bdin, 0);
    chk("rst_rdata", rdata, 0);

    bwr(10'h000, 32'hA); bwr(10'h001, 32'hB); bwr(10'h3FF, 32'hC);
    bwr(10'h020, 32'h11223344); bwr(10'h030, 32'h11223344);
    bwr(10'h040, 32'h01020304); bwr(10'h050, 32'h0);
    rst = 1'b0;
    tick();

    // back-to-back reads
    drv(1, 1, 0, 10'h000, 0, 4'h0); #1;
    chk("rd0_en", 32'(en), 1);
    chk("rd0_we", 32'(bwe), 0);
    chk("rd0_stall", 32'(stall), 0);
    tick();
    chk("rd0_ack", 32'(ack), 1); chk("rd0_data", rdata, 32'hA);
    drv(1, 1, 0, 10'h001, 0, 4'h0);
    tick();
    chk("rd1_ack", 32'(ack), 1); chk("rd1_data", rdata, 32'hB);
    chk("rd1_stall", 32'(stall), 0);
    drv(1, 1, 0, 10'h3FF, 0, 4'h0); #1;
    chk("rd2_addr", 32'(baddr), 32'h3FF);
    tick();
    chk("rd2_ack", 32'(ack), 1); chk("rd2_data", rdata, 32'hC);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("rd_idle_ack", 32'(ack), 0);

    // full write then read
    drv(1, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF); #1;
    chk("fw_en", 32'(en), 1); chk("fw_we", 32'(bwe), 1);
    chk("fw_din", bdin, 32'hDEADBEEF);
    tick();
    chk("fw_ack", 32'(ack), 1); chk("fw_rdata0", rdata, 0);
    drv(1, 1, 0, 10'h010, 0, 4'h0);
    tick();
    chk("fw_rb", rdata, 32'hDEADBEEF);
    drv(0, 0, 0, 0, 0, 0);
    tick();

    // partial write: read-modify-write
    drv(1, 1, 1, 10'h020, 32'hAABBCCDD, 4'b0101); #1;
    chk("pw_en", 32'(en), 1); chk("pw_we", 32'(bwe), 0);
    chk("pw_stall0", 32'(stall), 0);
    tick();
    chk("pw_stall1", 32'(stall), 1); chk("pw_ack1", 32'(ack), 0);
    chk("pw_mwe", 32'(bwe), 1); chk("pw_maddr", 32'(baddr), 32'h020);
    chk("pw_mdin", bdin, 32'h11BB33DD);
    tick();
    chk("pw_ack2", 32'(ack), 1); chk("pw_stall2", 32'(stall), 0);
    chk("pw_rdata", rdata, 0);
    drv(1, 1, 0, 10'h020, 0, 4'h0);
    tick();
    chk("pw_rb_ack", 32'(ack), 1); chk("pw_rb", rdata, 32'h11BB33DD);
    drv(0, 0, 0, 0, 0, 0);
    tick();

    // cycle abort during merge, then sel=0 write
    drv(1, 1, 1, 10'h040, 32'hF0F0F0F0, 4'b1000);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("ab_ack", 32'(ack), 0);
    drv(1, 1, 1, 10'h040, 32'hFFFFFFFF, 4'h0); #1;
    chk("s0_en", 32'(en), 0);
    tick();
    chk("s0_ack", 32'(ack), 1);
    drv(1, 1, 0, 10'h040, 0, 4'h0);
    tick();
    chk("ab_rb", rdata, 32'hF0020304);
    drv(0, 0, 0, 0, 0, 0);
    tick();

    // collision with port B
    drv(1, 1, 1, 10'h050, 32'h9, 4'hF);
    pb_we = 1'b1; pb_addr = 10'h050; pb_din = 32'h5;
    tick();
    pb_we = 1'b0;
    chk("col_ack", 32'(ack), 1);
    drv(1, 1, 0, 10'h050, 0, 4'h0);
    tick();
    chk("col_rb", rdata, 32'h9);
    drv(0, 0, 0, 0, 0, 0);
    tick();

    // reset in the middle of a merge
    drv(1, 1, 1, 10'h030, 32'hFFFFFFFF, 4'b0011);
    tick();
    chk("rm_stall", 32'(stall), 1);
    rst = 1'b1; #1;
    chk("rm_ack", 32'(ack), 0); chk("rm_stall0", 32'(stall), 0);
    chk("rm_en", 32'(en), 0);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    drv(1, 1, 0, 10'h030, 0, 4'h0);
    tick();
    chk("rm_rb", rdata, 32'h11223344);
    drv(0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
